// File: rtl/alu_seq_if.sv
// Request/result handshake bundle between a client and the alu_seq sequencer.
interface alu_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_z;
    logic        res_err;

    modport master (
        output in_valid, in_op, in_a, in_b, res_ready,
        input  in_ready, res_valid, res_data, res_z, res_err
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, res_ready,
        output in_ready, res_valid, res_data, res_z, res_err
    );
endinterface

// File: rtl/alu_seq.sv
// Sequencer that issues one operation at a time to an external registered ALU.
// Optional macro ALU_SEQ_TRAP_EN: op 15 completes immediately with res_err = 1.
//
// state   | meaning
// IDLE    | in_ready = 1, waiting for a request
// ISSUE   | decoded opcode and latched operands presented to the ALU
// CAPTURE | ALU result registered into res_data/res_z
// DONE    | res_valid = 1, waiting for res_ready
module alu_seq (
    input  logic        clk_n,
    input  logic        rst_n,
    alu_seq_if.slave    bus,
    output logic [10:0] alu_opcode,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_out,
    input  logic        alu_z,
    output logic [15:0] op_count
);

    localparam logic [10:0] OPC_NOOP = 11'b00000000001;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  op_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [15:0] data_q;
    logic        z_q;
    logic [15:0] count_q;
    logic        accept;
    logic        trap_op;

    function automatic logic [10:0] decode(input logic [3:0] op);
        case (op)
            4'd0:    decode = 11'b00000000001;
            4'd1:    decode = 11'b00000000010;
            4'd2:    decode = 11'b00000000100;
            4'd3:    decode = 11'b00000001000;
            4'd4:    decode = 11'b00000010000;
            4'd5:    decode = 11'b00000100000;
            4'd6:    decode = 11'b00001000000;
            4'd7:    decode = 11'b00010000000;
            4'd8:    decode = 11'b00100000000;
            4'd9:    decode = 11'b01000000000;
            4'd10:   decode = 11'b10000000000;
            4'd11:   decode = 11'b11111111000;
            4'd12:   decode = 11'b11111111110;
            4'd13:   decode = 11'b11111111101;
            4'd14:   decode = 11'b11111111011;
            default: decode = OPC_NOOP;
        endcase
    endfunction

    assign accept = (state == IDLE) && bus.in_valid;

`ifdef ALU_SEQ_TRAP_EN
    assign trap_op = (bus.in_op == 4'hF);
`else
    assign trap_op = 1'b0;
`endif

    always_ff @(posedge clk_n or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = trap_op ? DONE : ISSUE;
            ISSUE:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = DONE;
            DONE:    if (bus.res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.res_valid = (state == DONE);
    assign alu_opcode    = (state == ISSUE) ? decode(op_q) : OPC_NOOP;
    assign alu_a         = a_q;
    assign alu_b         = b_q;
    assign bus.res_data  = data_q;
    assign bus.res_z     = z_q;
    assign op_count      = count_q;

    // Trapped requests leave the operand registers alone so the ALU never sees them.
    always_ff @(posedge clk_n or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= 4'd0;
            a_q    <= 16'd0;
            b_q    <= 16'd0;
            data_q <= 16'd0;
            z_q    <= 1'b0;
        end else begin
            if (accept && !trap_op) begin
                op_q <= bus.in_op;
                a_q  <= bus.in_a;
                b_q  <= bus.in_b;
            end
            if (accept && trap_op) begin
                data_q <= 16'd0;
                z_q    <= 1'b1;
            end else if (state == CAPTURE) begin
                data_q <= alu_out;
                z_q    <= alu_z;
            end
        end
    end

`ifdef ALU_SEQ_TRAP_EN
    logic err_q;

    always_ff @(posedge clk_n or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= trap_op;
        end
    end

    assign bus.res_err = err_q;
`else
    assign bus.res_err = 1'b0;
`endif

    always_ff @(posedge clk_n or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 16'd0;
        end else if ((state == DONE) && bus.res_ready) begin
            count_q <= count_q + 16'd1;
        end
    end

endmodule
